// File: rtl/vending_machine_param.sv
// Parametrised multi-item vending controller: coin credit, per-item stock,
// validated purchases, largest-first change return, cancel, timeout and restock.
module vending_machine_param #(
  parameter int                          NUM_ITEMS  = 4,
  parameter int                          SEL_W      = 2,
  parameter int                          VAL_W      = 6,
  parameter logic [NUM_ITEMS*VAL_W-1:0]  PRICES     = {6'd15, 6'd12, 6'd10, 6'd5},
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_INIT = 3,
  parameter int                          TIMEOUT    = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           coin_in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 buy,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 dispense,
  output logic [SEL_W-1:0]     item_out,
  output logic [1:0]           change_out,
  output logic                 coin_reject,
  output logic                 error,
  output logic [VAL_W-1:0]     credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [TMR_W-1:0]   timer;
  logic [STOCK_W-1:0] stock [NUM_ITEMS];

  logic [VAL_W-1:0]   coin_val;
  logic [VAL_W:0]     coin_sum;
  logic               coin_present;
  logic               coin_fits;
  logic               sel_valid;
  logic               sel_stocked;
  logic [VAL_W-1:0]   sel_price;
  logic [VAL_W-1:0]   vend_price;
  logic [VAL_W-1:0]   vend_rem;
  logic               buy_ok;
  logic [1:0]         change_code;
  logic [VAL_W-1:0]   change_val;
  logic               collect_idle;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    coin_val = '0;
    case (coin_in)
      2'b01:   coin_val = VAL_W'(1);
      2'b10:   coin_val = VAL_W'(2);
      2'b11:   coin_val = VAL_W'(5);
      default: coin_val = '0;
    endcase
    coin_present = (coin_in != 2'b00);
    // One extra bit catches credit overflow instead of wrapping.
    coin_sum     = {1'b0, credit} + {1'b0, coin_val};
    coin_fits    = !coin_sum[VAL_W];

    sel_valid   = (int'(sel) < NUM_ITEMS);
    sel_price   = '0;
    sel_stocked = 1'b0;
    vend_price  = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_price   = PRICES[i*VAL_W +: VAL_W];
        sel_stocked = (stock[i] != '0);
      end
      if (sel_q == SEL_W'(i)) vend_price = PRICES[i*VAL_W +: VAL_W];
    end
    buy_ok   = sel_valid && sel_stocked && (credit >= sel_price);
    vend_rem = credit - vend_price;

    if (credit >= VAL_W'(5)) begin
      change_code = 2'b11;
      change_val  = VAL_W'(5);
    end else if (credit >= VAL_W'(2)) begin
      change_code = 2'b10;
      change_val  = VAL_W'(2);
    end else begin
      change_code = 2'b01;
      change_val  = VAL_W'(1);
    end

    // A COLLECT cycle with nothing accepted advances the inactivity timer.
    collect_idle = !cancel && !(buy && buy_ok) && !(!buy && coin_present && coin_fits);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      sel_q       <= '0;
      timer       <= '0;
      credit      <= '0;
      dispense    <= 1'b0;
      item_out    <= '0;
      change_out  <= 2'b00;
      coin_reject <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      sold_out    <= {NUM_ITEMS{STOCK_INIT == 0}};
      // NOTE: the stock array is a handful of flops with a defined power-up
      // value, so it is reset explicitly rather than left to a RAM.
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      dispense    <= 1'b0;
      item_out    <= '0;
      change_out  <= 2'b00;
      coin_reject <= 1'b0;
      error       <= 1'b0;

      case (state)
        S_IDLE: begin
          error <= buy;
          if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
            sold_out <= {NUM_ITEMS{STOCK_INIT == 0}};
          end
          if (coin_present) begin
            state  <= S_COLLECT;
            credit <= coin_val;
            timer  <= '0;
          end
        end

        S_COLLECT: begin
          if (cancel) begin
            state       <= S_CHANGE;
            busy        <= 1'b1;
            coin_reject <= coin_present;
          end else if (buy) begin
            coin_reject <= coin_present;
            if (buy_ok) begin
              sel_q <= sel;
              timer <= '0;
              state <= S_VEND;
              busy  <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end else if (coin_present) begin
            if (coin_fits) begin
              credit <= coin_sum[VAL_W-1:0];
              timer  <= '0;
            end else begin
              coin_reject <= 1'b1;
            end
          end
          if (collect_idle) begin
            if (timer == TMR_W'(TIMEOUT - 1)) begin
              timer <= '0;
              state <= S_CHANGE;
              busy  <= 1'b1;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end

        S_VEND: begin
          coin_reject <= coin_present;
          error       <= buy;
          dispense    <= 1'b1;
          item_out    <= sel_q;
          credit      <= vend_rem;
          for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_q == SEL_W'(i)) begin
              stock[i]    <= stock[i] - STOCK_W'(1);
              sold_out[i] <= (stock[i] == STOCK_W'(1));
            end
          end
          if (vend_rem != '0) begin
            state <= S_CHANGE;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_CHANGE: begin
          coin_reject <= coin_present;
          error       <= buy;
          change_out  <= change_code;
          credit      <= credit - change_val;
          if (credit == change_val) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed self-checking bench for vending_machine_param with default parameters
// (prices 5/10/12/15 for items 0..3, stock 3, timeout 255).
module tb_vending_machine_param;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] coin_in;
  logic [1:0] sel;
  logic       buy, cancel, restock;
  logic       dispense;
  logic [1:0] item_out;
  logic [1:0] change_out;
  logic       coin_reject;
  logic       error;
  logic [5:0] credit;
  logic [3:0] sold_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] C1 = 2'b01, C2 = 2'b10, C5 = 2'b11, CN = 2'b00;

  vending_machine_param dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .coin_in     (coin_in),
    .sel         (sel),
    .buy         (buy),
    .cancel      (cancel),
    .restock     (restock),
    .dispense    (dispense),
    .item_out    (item_out),
    .change_out  (change_out),
    .coin_reject (coin_reject),
    .error       (error),
    .credit      (credit),
    .sold_out    (sold_out),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, sample 1 ns later.
  task automatic tick(input logic [1:0] c, input logic b, input logic [1:0] s,
                      input logic x, input logic r);
    coin_in = c; buy = b; sel = s; cancel = x; restock = r;
    @(posedge clock);
    #1;
    coin_in = CN; buy = 1'b0; sel = 2'd0; cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic coin(input logic [1:0] c);
    tick(c, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(CN, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic purchase(input logic [1:0] s);
    tick(CN, 1'b1, s, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int coins, total;
    logic [1:0] first_code;

    reset_n = 1'b0; coin_in = CN; sel = 2'd0; buy = 1'b0; cancel = 1'b0; restock = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_dispense", dispense, 0);
    check("rst_change", change_out, 0);
    check("rst_error", error, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_sold_out", sold_out, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Exact credit 12 for item 2: dispense, no change.
    coin(C5); coin(C5); coin(C2);
    check("t1_credit", credit, 12);
    purchase(2'd2);
    check("t1_vend_busy", busy, 1);
    check("t1_vend_nodisp", dispense, 0);
    idle();
    check("t1_dispense", dispense, 1);
    check("t1_item", item_out, 2);
    check("t1_credit0", credit, 0);
    check("t1_idle", busy, 0);
    check("t1_nochange", change_out, 0);
    idle();
    check("t1_disp_pulse", dispense, 0);
    check("t1_nochange2", change_out, 0);

    // Credit 15 for item 1 (10): one 5Rs coin back.
    coin(C5); coin(C5); coin(C5);
    purchase(2'd1);
    idle();
    check("t2_dispense", dispense, 1);
    check("t2_item", item_out, 1);
    check("t2_credit", credit, 5);
    check("t2_busy", busy, 1);
    idle();
    check("t2_change", change_out, 3);
    check("t2_credit0", credit, 0);
    check("t2_idle", busy, 0);

    // Insufficient credit: refusal, then cancel returns 5 then 2.
    coin(C5); coin(C2);
    purchase(2'd1);
    check("t3_error", error, 1);
    check("t3_credit", credit, 7);
    check("t3_busy", busy, 0);
    tick(CN, 1'b0, 2'd0, 1'b1, 1'b0);
    check("t3_error_pulse", error, 0);
    check("t3_cancel_busy", busy, 1);
    idle();
    check("t3_change5", change_out, 3);
    check("t3_credit2", credit, 2);
    idle();
    check("t3_change2", change_out, 2);
    check("t3_credit0", credit, 0);
    check("t3_idle", busy, 0);

    // Drain item 0, refuse a fourth buy, refund, restock.
    for (int k = 0; k < 3; k++) begin
      coin(C5);
      purchase(2'd0);
      idle();
      check("t4_dispense", dispense, 1);
      check("t4_credit0", credit, 0);
    end
    check("t4_sold_out", sold_out, 4'b0001);
    coin(C5);
    purchase(2'd0);
    check("t4_refuse", error, 1);
    check("t4_refuse_credit", credit, 5);
    tick(CN, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    check("t4_refund", change_out, 3);
    check("t4_refund_credit", credit, 0);
    tick(CN, 1'b0, 2'd0, 1'b0, 1'b1);
    check("t4_restock", sold_out, 4'b0000);

    // Coin during CHANGE is rejected and does not touch credit.
    coin(C5); coin(C5);
    tick(CN, 1'b0, 2'd0, 1'b1, 1'b0);
    coin(C1);
    check("t5_chg_reject", coin_reject, 1);
    check("t5_chg_credit", credit, 5);
    idle();
    check("t5_reject_pulse", coin_reject, 0);
    check("t5_chg_done", credit, 0);

    // Saturation at the top of the credit range.
    for (int k = 0; k < 12; k++) coin(C5);
    check("t5_credit60", credit, 60);
    coin(C5);
    check("t5_ovf_reject", coin_reject, 1);
    check("t5_ovf_credit", credit, 60);
    coin(C2);
    check("t5_62_accept", coin_reject, 0);
    check("t5_credit62", credit, 62);
    coin(C2);
    check("t5_64_reject", coin_reject, 1);
    coin(C1);
    check("t5_credit63", credit, 63);
    tick(C1, 1'b0, 2'd0, 1'b1, 1'b0);
    check("t5_cancel_reject", coin_reject, 1);
    check("t5_cancel_credit", credit, 63);
    coins = 0; total = 0; first_code = 2'b00;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (change_out != 2'b00) begin
        if (coins == 0) first_code = change_out;
        coins++;
        total += (change_out == C5) ? 5 : (change_out == C2) ? 2 : 1;
      end
      if (!busy) break;
    end
    check("t5_drain_done", busy, 0);
    check("t5_drain_total", total, 63);
    check("t5_drain_coins", coins, 14);
    check("t5_first_coin", first_code, 3);
    check("t5_drain_credit", credit, 0);
    purchase(2'd0);
    check("t5_idle_buy_err", error, 1);

    // Inactivity timeout: refund fires after 255 idle cycles.
    coin(C1);
    repeat (254) idle();
    check("t6_pre_timeout", busy, 0);
    check("t6_pre_credit", credit, 1);
    idle();
    check("t6_timeout_busy", busy, 1);
    check("t6_timeout_nochg", change_out, 0);
    idle();
    check("t6_refund", change_out, 1);
    check("t6_credit0", credit, 0);
    check("t6_idle", busy, 0);

    // Reset in the middle of CHANGE.
    coin(C5); coin(C5); coin(C5);
    purchase(2'd0);
    idle();
    check("t7_pre_credit", credit, 10);
    check("t7_pre_busy", busy, 1);
    reset_n = 1'b0;
    #2;
    check("t7_rst_credit", credit, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_change", change_out, 0);
    check("t7_rst_dispense", dispense, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    check("t7_post_change", change_out, 0);
    for (int k = 0; k < 3; k++) begin
      check("t7_not_sold_out", sold_out, 4'b0000);
      coin(C5);
      purchase(2'd0);
      idle();
      check("t7_dispense", dispense, 1);
    end
    check("t7_stock3", sold_out, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised multi-item vending controller and the successor to the two-item chocolate dispenser. It accepts coins into a credit register and tracks per-item stock. On a buy request it validates the selection against price and stock, then dispenses one item and returns change one coin per cycle, largest denomination first. It also supports cancel/refund, an inactivity timeout and restock, and sits between the coin acceptor front-end and the item/coin actuator drivers.

Parameters:
NUM_ITEMS, 4, number of selectable items (2..16)
SEL_W, 2, selection width, must satisfy 2**SEL_W >= NUM_ITEMS
VAL_W, 6, credit/price width in Rs; maximum credit is 2**VAL_W-1
PRICES, {6'd15,6'd12,6'd10,6'd5}, packed NUM_ITEMS*VAL_W prices, item 0 in the LSBs
STOCK_W, 4, per-item stock counter width
STOCK_INIT, 3, stock loaded into every item at reset and on restock
TIMEOUT, 255, idle cycles in COLLECT before an automatic refund

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  reset
coin_in  in  2  00 none, 01 1Rs, 10 2Rs, 11 5Rs; sampled every cycle
sel  in  SEL_W  item index; sampled only when buy=1
buy  in  1  purchase request
cancel  in  1  refund request
restock  in  1  reload all stock; honoured in IDLE only
dispense  out  1  one-cycle pulse when an item is released
item_out  out  SEL_W  index of the dispensed item; valid while dispense=1
change_out  out  2  coin returned this cycle, same encoding as coin_in; 00 = none
coin_reject  out  1  one-cycle pulse: the coin sampled last cycle was not accepted
error  out  1  one-cycle pulse: the buy request sampled last cycle was refused
credit  out  VAL_W  current credit
sold_out  out  NUM_ITEMS  bit i is set while stock[i]==0
busy  out  1  high in VEND and CHANGE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, credit=0, all stock=STOCK_INIT, timeout counter=0, and dispense/item_out/change_out/coin_reject/error/busy=0. sold_out is 0 when STOCK_INIT>0.
- Timing: all outputs are registered. Every input effect appears one clock after the input is sampled.
- States: IDLE, COLLECT, VEND, CHANGE.
- IDLE (credit is always 0):
  - A non-zero coin moves to COLLECT with credit=coin value.
  - restock reloads all stock.
  - buy asserts error.
  - cancel is ignored.
- COLLECT, per-cycle priority is cancel > buy > coin:
  - cancel moves to CHANGE (full refund). A coin in the same cycle is rejected.
  - buy is refused (error=1, state and credit unchanged) if sel>=NUM_ITEMS, or stock[sel]==0, or credit<PRICES[sel]. A coin in the same cycle is rejected.
  - buy is otherwise accepted: latch sel and go to VEND. A coin in the same cycle is rejected.
  - A coin on its own adds to credit. If credit+value > 2**VAL_W-1, the coin is rejected and credit is unchanged; there is no wrap-around.
  - Timeout counter: cleared on any accepted coin or buy, incremented otherwise. When it reaches TIMEOUT, go to CHANGE.
  - restock is ignored.
- VEND (one cycle):
  - dispense=1 and item_out=latched sel.
  - stock[sel] decrements by 1 and credit decrements by PRICES[sel].
  - Go to CHANGE if the remaining credit >0, else IDLE.
- CHANGE:
  - Each cycle emit the largest coin <= credit (5, then 2, then 1) and subtract it from credit.
  - When credit reaches 0, go to IDLE.
- Coins arriving in VEND or CHANGE are rejected. buy arriving in VEND or CHANGE asserts error. cancel and restock in VEND or CHANGE are ignored.
- Stock never decrements below 0, because a refused buy never reaches VEND.
- Reset asserted mid-operation returns immediately to reset values. Pending change is discarded and no partial coin is output.

Test Plan:
- 5,5,2 coins, then buy sel=2 (price 12) -> credit 12; next cycle dispense=1, item_out=2; credit 0; state returns to IDLE; change_out stays 00.
- 5,5,5 coins, then buy sel=1 (price 10) -> dispense item 1; next cycle change_out=11 (5Rs); credit 0; IDLE.
- 5,2 coins (credit 7), then buy sel=1 -> error pulse, credit stays 7. Then cancel -> change_out 11 then 10 on consecutive cycles; credit 0; IDLE.
- Buy item 0 three times with 5Rs each -> sold_out[0]=1 after the third. A fourth buy with credit 5 -> error, refunded by cancel. restock in IDLE -> sold_out[0]=0.
- Coin arriving during CHANGE -> coin_reject pulse, credit unaffected. Credit 60 plus a 5Rs coin -> coin_reject, credit stays 60.
- 1Rs coin then 255 idle cycles -> change_out=01 on the cycle after the timeout, then IDLE. Reset_n low mid-CHANGE -> all outputs 0, stock back to 3.
